// File: rtl/chain_deskew.sv
// rtl/chain_deskew.sv - realigns staggered delay-chain taps into one wavefront and queues it in a FWFT FIFO
module chain_deskew #(
    parameter int DWIDTH     = 1,
    parameter int LANES      = 1,
    parameter int DEPTH      = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:DEPTH-1]  i_valid,
    input  logic [DWIDTH-1:0] i_data [0:DEPTH-1][0:LANES-1],
    input  logic              i_clr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DWIDTH-1:0] o_data [0:DEPTH-1][0:LANES-1],
    output logic              o_almost_full,
    output logic              o_err,
    output logic              o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = LANES * DWIDTH;
    localparam int WW = DEPTH * SW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(FIFO_DEPTH - DEPTH - 1);

    logic [0:DEPTH-1] av;
    logic [WW-1:0]    wf_al;
    logic [WW-1:0]    head;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [SW-1:0] s_in;
        logic [SW-1:0] s_al;

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign s_in[l*DWIDTH +: DWIDTH] = i_data[k][l];
        end

        // Later stages already lag stage 0 by k cycles, so they need fewer registers.
        if (k == DEPTH - 1) begin : g_direct
            assign av[k] = i_valid[k];
            assign s_al  = s_in;
        end else begin : g_delay
            localparam int N = DEPTH - 1 - k;
            logic [N-1:0]  v_q;
            logic [SW-1:0] d_q [0:N-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                    for (int i = 0; i < N; i++) d_q[i] <= '0;
                end else begin
                    v_q[0] <= i_valid[k];
                    d_q[0] <= s_in;
                    for (int i = 1; i < N; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign av[k] = v_q[N-1];
            assign s_al  = d_q[N-1];
        end

        assign wf_al[k*SW +: SW] = s_al;

        for (genvar l = 0; l < LANES; l++) begin : g_out
            assign o_data[k][l] = head[(k*LANES + l)*DWIDTH +: DWIDTH];
        end
    end

    logic [WW-1:0]   mem_q [0:FIFO_DEPTH-1];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            af_q, af_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            all_v, any_v, full, pop, push;

    always_comb begin
        all_v    = &av;
        any_v    = |av;
        full     = (count_q == FULL_CNT);
        pop      = (count_q != '0) & i_ready;
        // A pop frees the slot the write lands in, so a full FIFO still accepts.
        push     = all_v & (~full | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push & ~pop)      count_d = count_q + 1'b1;
        else if (pop & ~push) count_d = count_q - 1'b1;
        af_d  = (count_d >= AF_CNT);
        err_d = (any_v & ~all_v) | (err_q & ~i_clr);
        ovf_d = (all_v & full & ~pop) | (ovf_q & ~i_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            af_q     <= af_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wf_al;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign o_valid       = (count_q != '0);
    assign o_almost_full = af_q;
    assign o_err         = err_q;
    assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_chain_deskew.sv
// tb/tb_chain_deskew.sv - randomized and directed bench for chain_deskew against a queue-level model
module tb_chain_deskew;
    localparam int DW    = 8;
    localparam int LN    = 2;
    localparam int DP    = 4;
    localparam int FD    = 8;
    localparam int WW    = DP * LN * DW;
    localparam int SW    = LN * DW;
    localparam int AF_TH = FD - DP - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [0:DP-1] a_valid;
    logic [DW-1:0] a_data [0:DP-1][0:LN-1];
    logic          a_clr, a_ready, a_o_valid, a_af, a_err, a_ovf;
    logic [DW-1:0] a_o_data [0:DP-1][0:LN-1];

    logic [0:0]    b_valid;
    logic [DW-1:0] b_data [0:0][0:0];
    logic          b_clr, b_ready, b_o_valid, b_af, b_err, b_ovf;
    logic [DW-1:0] b_o_data [0:0][0:0];

    chain_deskew #(.DWIDTH(DW), .LANES(LN), .DEPTH(DP), .FIFO_DEPTH(FD)) u_a (
        .clk(clk), .rst(rst), .i_valid(a_valid), .i_data(a_data), .i_clr(a_clr),
        .o_valid(a_o_valid), .i_ready(a_ready), .o_data(a_o_data),
        .o_almost_full(a_af), .o_err(a_err), .o_overflow(a_ovf)
    );

    chain_deskew #(.DWIDTH(DW), .LANES(1), .DEPTH(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .i_valid(b_valid), .i_data(b_data), .i_clr(b_clr),
        .o_valid(b_o_valid), .i_ready(b_ready), .o_data(b_o_data),
        .o_almost_full(b_af), .o_err(b_err), .o_overflow(b_ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: history of what each stage was driven with, plus the FIFO as a queue of wavefronts.
    logic [WW-1:0] mq[$];
    logic          m_err, m_ovf, m_af;
    logic [0:DP-1] hv[$];
    logic [WW-1:0] hd[$];
    logic          ih_v[$];
    logic [WW-1:0] ih_w[$];

    function automatic logic [WW-1:0] a_out();
        logic [WW-1:0] r;
        for (int k = 0; k < DP; k++)
            for (int l = 0; l < LN; l++)
                r[(k*LN + l)*DW +: DW] = a_o_data[k][l];
        return r;
    endfunction

    task automatic model_clear();
        mq.delete(); hv.delete(); hd.delete(); ih_v.delete(); ih_w.delete();
        for (int i = 0; i < DP; i++) begin
            hv.push_back('0); hd.push_back('0); ih_v.push_back(1'b0); ih_w.push_back('0);
        end
        m_err = 1'b0; m_ovf = 1'b0; m_af = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = '0; a_clr = 1'b0; a_ready = 1'b0;
        for (int k = 0; k < DP; k++) for (int l = 0; l < LN; l++) a_data[k][l] = '0;
        b_valid = '0; b_data[0][0] = '0; b_clr = 1'b0; b_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_cycle(input logic [0:DP-1] v, input logic [WW-1:0] d,
                               input logic rdy, input logic clr);
        logic [0:DP-1] av, tv;
        logic [WW-1:0] ad, td;
        logic          all_v, any_v, pop, push, full;
        a_valid = v; a_ready = rdy; a_clr = clr;
        for (int k = 0; k < DP; k++)
            for (int l = 0; l < LN; l++)
                a_data[k][l] = d[(k*LN + l)*DW +: DW];
        hv.push_front(v); hd.push_front(d);
        if (hv.size() > DP) begin hv.delete(hv.size() - 1); hd.delete(hd.size() - 1); end
        for (int k = 0; k < DP; k++) begin
            tv = hv[DP-1-k]; td = hd[DP-1-k];
            av[k] = tv[k];
            ad[k*SW +: SW] = td[k*SW +: SW];
        end
        all_v = &av; any_v = |av;
        pop   = (mq.size() != 0) && rdy;
        full  = (mq.size() == FD);
        push  = all_v && (!full || pop);
        m_ovf = (all_v && full && !pop) || (m_ovf && !clr);
        m_err = (any_v && !all_v) || (m_err && !clr);
        if (pop)  mq.delete(0);
        if (push) mq.push_back(ad);
        m_af = (mq.size() >= AF_TH);
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic issue, input logic [WW-1:0] wf, input logic rdy,
                        input logic clr, input logic [0:DP-1] flip);
        logic [0:DP-1] v;
        logic [WW-1:0] d, w;
        ih_v.push_front(issue); ih_w.push_front(wf);
        if (ih_v.size() > DP) begin ih_v.delete(ih_v.size() - 1); ih_w.delete(ih_w.size() - 1); end
        for (int k = 0; k < DP; k++) begin
            v[k] = ih_v[k];
            w = ih_w[k];
            d[k*SW +: SW] = w[k*SW +: SW];
        end
        drive_cycle(v ^ flip, d, rdy, clr);
    endtask

    task automatic b_cycle(input logic v, input logic [DW-1:0] d, input logic rdy);
        b_valid = v; b_data[0][0] = d; b_ready = rdy;
        @(posedge clk);
        #1;
        b_valid = '0; b_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (a_o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b expected 0", a_o_valid); else n_pass++;
        n_checks++; if (a_af !== 1'b0) $display("FAIL reset_almost_full: got %b expected 0", a_af); else n_pass++;
        n_checks++; if (a_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", a_err); else n_pass++;
        n_checks++; if (a_ovf !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", a_ovf); else n_pass++;
        n_checks++; if (b_o_valid !== 1'b0) $display("FAIL reset_b_o_valid: got %b expected 0", b_o_valid); else n_pass++;
    endtask

    task automatic test_single();
        logic [WW-1:0] w;
        do_reset();
        for (int k = 0; k < DP; k++)
            for (int l = 0; l < LN; l++)
                w[(k*LN + l)*DW +: DW] = 8'(16*k + l);
        for (int i = 0; i < DP; i++) begin
            tick(i == 0, w, 1'b0, 1'b0, '0);
            n_checks++;
            if (a_o_valid !== (i == DP - 1))
                $display("FAIL single_latency: cycle %0d got %b expected %b", i + 1, a_o_valid, i == DP - 1);
            else n_pass++;
        end
        n_checks++; if (a_out() !== w) $display("FAIL single_data: got %h expected %h", a_out(), w); else n_pass++;
        tick(1'b0, '0, 1'b1, 1'b0, '0);
        n_checks++; if (a_o_valid !== 1'b0) $display("FAIL single_pop: got %b expected 0", a_o_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] eq[$];
        logic [WW-1:0] w;
        int nout = 0;
        do_reset();
        for (int c = 0; c < 20 + DP + 2; c++) begin
            w = {$urandom, $urandom};
            if (c < 20) eq.push_back(w);
            tick(c < 20, w, 1'b1, 1'b0, '0);
            n_checks++;
            if (a_o_valid !== (c >= DP - 1 && c < 20 + DP - 1))
                $display("FAIL b2b_valid: cycle %0d got %b expected %b", c, a_o_valid, c >= DP - 1 && c < 20 + DP - 1);
            else n_pass++;
            if (a_o_valid === 1'b1) begin
                n_checks++;
                if (eq.size() == 0) $display("FAIL b2b_extra: got output expected none");
                else if (a_out() !== eq[0]) $display("FAIL b2b_data: got %h expected %h", a_out(), eq[0]);
                else n_pass++;
                if (eq.size() != 0) eq.delete(0);
                nout++;
            end
        end
        n_checks++; if (nout !== 20) $display("FAIL b2b_count: got %0d expected 20", nout); else n_pass++;
        n_checks++; if ({a_af, a_err, a_ovf} !== 3'b000) $display("FAIL b2b_flags: got %b expected 000", {a_af, a_err, a_ovf}); else n_pass++;
    endtask

    task automatic test_stall();
        logic [WW-1:0] eq[$];
        logic [WW-1:0] w;
        logic stopped = 1'b0;
        int n_iss = 0, nd = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (a_af === 1'b1) stopped = 1'b1;
            w = {$urandom, $urandom};
            if (!stopped) begin eq.push_back(w); n_iss++; end
            tick(!stopped, w, 1'b0, 1'b0, '0);
            n_checks++;
            if (a_af !== m_af) $display("FAIL stall_af: cycle %0d got %b expected %b", c, a_af, m_af); else n_pass++;
        end
        n_checks++; if (n_iss !== AF_TH + DP - 1) $display("FAIL stall_issued: got %0d expected %0d", n_iss, AF_TH + DP - 1); else n_pass++;
        n_checks++; if (a_ovf !== 1'b0) $display("FAIL stall_overflow: got %b expected 0", a_ovf); else n_pass++;
        for (int c = 0; c < FD + 4; c++) begin
            if (a_o_valid === 1'b1) begin
                n_checks++;
                if (eq.size() == 0 || a_out() !== eq[0]) $display("FAIL stall_drain_data: got %h expected %h", a_out(), (eq.size() != 0) ? eq[0] : '0);
                else n_pass++;
                if (eq.size() != 0) eq.delete(0);
                nd++;
            end
            tick(1'b0, '0, 1'b1, 1'b0, '0);
        end
        n_checks++; if (nd !== n_iss) $display("FAIL stall_drain_count: got %0d expected %0d", nd, n_iss); else n_pass++;
        n_checks++; if (a_af !== 1'b0) $display("FAIL stall_af_release: got %b expected 0", a_af); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [WW-1:0] eq[$];
        logic [WW-1:0] w;
        int nd = 0;
        do_reset();
        for (int c = 0; c < FD + 1; c++) begin
            w = {$urandom, $urandom};
            eq.push_back(w);
            tick(1'b1, w, 1'b0, 1'b0, '0);
        end
        repeat (DP + 1) tick(1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++; if (a_ovf !== 1'b1) $display("FAIL ovf_set: got %b expected 1", a_ovf); else n_pass++;
        n_checks++; if (a_err !== 1'b0) $display("FAIL ovf_err: got %b expected 0", a_err); else n_pass++;
        for (int c = 0; c < FD + 3; c++) begin
            if (a_o_valid === 1'b1) begin
                n_checks++;
                if (a_out() !== eq[nd]) $display("FAIL ovf_data: entry %0d got %h expected %h", nd, a_out(), eq[nd]);
                else n_pass++;
                nd++;
            end
            tick(1'b0, '0, 1'b1, 1'b0, '0);
        end
        n_checks++; if (nd !== FD) $display("FAIL ovf_count: got %0d expected %0d", nd, FD); else n_pass++;
        n_checks++; if (a_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", a_ovf); else n_pass++;
        tick(1'b0, '0, 1'b0, 1'b1, '0);
        n_checks++; if (a_ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", a_ovf); else n_pass++;
    endtask

    task automatic test_misalign();
        do_reset();
        drive_cycle(4'b1000, {$urandom, $urandom}, 1'b0, 1'b0);
        drive_cycle(4'b0000, {$urandom, $urandom}, 1'b0, 1'b0);
        drive_cycle(4'b0110, {$urandom, $urandom}, 1'b0, 1'b0);
        drive_cycle(4'b0001, {$urandom, $urandom}, 1'b0, 1'b0);
        repeat (3) drive_cycle('0, '0, 1'b0, 1'b0);
        n_checks++; if (a_err !== 1'b1) $display("FAIL misalign_err: got %b expected 1", a_err); else n_pass++;
        n_checks++; if (a_o_valid !== 1'b0) $display("FAIL misalign_no_push: got %b expected 0", a_o_valid); else n_pass++;
        drive_cycle('0, '0, 1'b0, 1'b1);
        n_checks++; if (a_err !== 1'b0) $display("FAIL misalign_clear: got %b expected 0", a_err); else n_pass++;
        drive_cycle(4'b0001, '0, 1'b0, 1'b1);
        n_checks++; if (a_err !== 1'b1) $display("FAIL misalign_set_wins: got %b expected 1", a_err); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [WW-1:0] eq[$];
        logic [WW-1:0] w;
        int nd = 0;
        do_reset();
        for (int c = 0; c < FD; c++) begin
            w = {$urandom, $urandom};
            eq.push_back(w);
            tick(1'b1, w, 1'b0, 1'b0, '0);
        end
        repeat (DP) tick(1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++; if (a_af !== 1'b1) $display("FAIL fpp_af_full: got %b expected 1", a_af); else n_pass++;
        w = {$urandom, $urandom};
        eq.push_back(w);
        tick(1'b1, w, 1'b0, 1'b0, '0);
        repeat (DP - 2) tick(1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++; if (a_out() !== eq[0]) $display("FAIL fpp_head: got %h expected %h", a_out(), eq[0]); else n_pass++;
        tick(1'b0, '0, 1'b1, 1'b0, '0);
        eq.delete(0);
        n_checks++; if (a_ovf !== 1'b0) $display("FAIL fpp_no_overflow: got %b expected 0", a_ovf); else n_pass++;
        n_checks++; if (a_af !== 1'b1) $display("FAIL fpp_still_full: got %b expected 1", a_af); else n_pass++;
        for (int c = 0; c < FD + 3; c++) begin
            if (a_o_valid === 1'b1) begin
                n_checks++;
                if (nd >= FD || a_out() !== eq[nd]) $display("FAIL fpp_order: entry %0d got %h", nd, a_out());
                else n_pass++;
                nd++;
            end
            tick(1'b0, '0, 1'b1, 1'b0, '0);
        end
        n_checks++; if (nd !== FD) $display("FAIL fpp_count: got %0d expected %0d", nd, FD); else n_pass++;
    endtask

    task automatic test_depth1();
        do_reset();
        b_cycle(1'b1, 8'h01, 1'b0);
        n_checks++; if (b_o_valid !== 1'b1) $display("FAIL d1_latency: got %b expected 1", b_o_valid); else n_pass++;
        n_checks++; if (b_o_data[0][0] !== 8'h01) $display("FAIL d1_data: got %h expected 01", b_o_data[0][0]); else n_pass++;
        for (int i = 2; i <= 4; i++) b_cycle(1'b1, 8'(i), 1'b0);
        n_checks++; if (b_af !== 1'b1) $display("FAIL d1_af: got %b expected 1", b_af); else n_pass++;
        b_cycle(1'b1, 8'h05, 1'b1);
        n_checks++; if (b_ovf !== 1'b0) $display("FAIL d1_no_overflow: got %b expected 0", b_ovf); else n_pass++;
        for (int i = 2; i <= 5; i++) begin
            n_checks++;
            if (b_o_valid !== 1'b1 || b_o_data[0][0] !== 8'(i))
                $display("FAIL d1_order: got %b/%h expected 1/%h", b_o_valid, b_o_data[0][0], 8'(i));
            else n_pass++;
            b_cycle(1'b0, '0, 1'b1);
        end
        n_checks++; if (b_o_valid !== 1'b0) $display("FAIL d1_empty: got %b expected 0", b_o_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic rdy, iss, clr;
        logic [0:DP-1] fl;
        logic [WW-1:0] w;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            n_checks++;
            if (a_o_valid !== (mq.size() != 0)) $display("FAIL rnd_valid: cycle %0d got %b expected %b", c, a_o_valid, mq.size() != 0); else n_pass++;
            if (mq.size() != 0) begin
                n_checks++;
                if (a_out() !== mq[0]) $display("FAIL rnd_data: cycle %0d got %h expected %h", c, a_out(), mq[0]); else n_pass++;
            end
            n_checks++; if (a_af !== m_af) $display("FAIL rnd_af: cycle %0d got %b expected %b", c, a_af, m_af); else n_pass++;
            n_checks++; if (a_err !== m_err) $display("FAIL rnd_err: cycle %0d got %b expected %b", c, a_err, m_err); else n_pass++;
            n_checks++; if (a_ovf !== m_ovf) $display("FAIL rnd_ovf: cycle %0d got %b expected %b", c, a_ovf, m_ovf); else n_pass++;
            rdy = (c < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            iss = ($urandom_range(0, 9) < 6) && (a_af == 1'b0 || $urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 19) == 0);
            fl  = ($urandom_range(0, 29) == 0) ? (DP'(1) << $urandom_range(0, DP - 1)) : '0;
            w   = {$urandom, $urandom};
            tick(iss, w, rdy, clr, fl);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b_cycle(1'b1, 8'hA5, 1'b0);
        b_cycle(1'b1, 8'h5A, 1'b0);
        for (int c = 0; c < FD + DP + 1; c++) tick(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, '0);
        n_checks++; if (a_ovf !== 1'b1 || b_o_valid !== 1'b1) $display("FAIL rmid_pre: got %b%b expected 11", a_ovf, b_o_valid); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({a_o_valid, a_af, a_err, a_ovf} !== 4'b0000) $display("FAIL rmid_a_flags: got %b expected 0000", {a_o_valid, a_af, a_err, a_ovf}); else n_pass++;
        n_checks++; if (a_out() !== '0) $display("FAIL rmid_a_data: got %h expected 0", a_out()); else n_pass++;
        n_checks++; if ({b_o_valid, b_af, b_o_data[0][0]} !== 10'd0) $display("FAIL rmid_b: got %h expected 0", {b_o_valid, b_af, b_o_data[0][0]}); else n_pass++;
        rst = 1'b0;
        model_clear();
        for (int c = 0; c < DP + 2; c++) begin
            tick(1'b0, '0, 1'b1, 1'b0, '0);
            n_checks++; if (a_o_valid !== 1'b0) $display("FAIL rmid_inflight: cycle %0d got %b expected 0", c, a_o_valid); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_misalign();
        test_full_push_pop();
        test_depth1();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
